// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with a programmable prescaler, run/pause control,
// one-shot or auto-reload operation and a terminal-count pulse.
module bcd_countdown_timer #(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_load,
    input  logic [4*DIGITS-1:0] i_load_val,
    input  logic                i_start,
    input  logic                i_pause,
    input  logic                i_auto_reload,
    output logic [4*DIGITS-1:0] o_bcd_out,
    output logic                o_running,
    output logic                o_done,
    output logic                o_tick,
    output logic                o_tc_pulse
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_DONE
    } state_t;

    state_t        r_state, w_state;
    logic [W-1:0]  r_bcd, w_bcd;
    logic [W-1:0]  r_reload, w_reload;
    logic [PW-1:0] r_presc, w_presc;
    logic          r_tick, w_tick;
    logic          r_tc, w_tc;

    // Any digit above 9 is forced to 9 so the count stays valid BCD.
    function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [3:0]   d;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            r[4*i +: 4] = (d > 4'd9) ? 4'd9 : d;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [3:0]   d;
        logic         borrow;
        r      = '0;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (!borrow) begin
                r[4*i +: 4] = d;
            end else if (d == 4'd0) begin
                r[4*i +: 4] = 4'd9;
            end else begin
                r[4*i +: 4] = d - 4'd1;
                borrow      = 1'b0;
            end
        end
        return r;
    endfunction

    always_comb begin
        w_state  = r_state;
        w_bcd    = r_bcd;
        w_reload = r_reload;
        w_presc  = r_presc;
        w_tick   = 1'b0;
        w_tc     = 1'b0;
        if (i_load) begin
            w_bcd    = clamp_bcd(i_load_val);
            w_reload = clamp_bcd(i_load_val);
            w_presc  = '0;
            w_state  = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start && !i_pause) begin
                        if (r_bcd == '0) begin
                            w_state = S_DONE;
                            w_tc    = 1'b1;
                        end else begin
                            w_state = S_RUN;
                            w_presc = '0;
                        end
                    end
                end
                S_RUN: begin
                    if (i_pause) begin
                        w_state = S_PAUSED;
                    end else if (r_presc != P_LAST) begin
                        w_presc = r_presc + PW'(1);
                    end else begin
                        // Prescaler wrap: this edge performs the count step.
                        w_presc = '0;
                        if (r_bcd == '0) begin
                            if (i_auto_reload) begin
                                w_bcd  = r_reload;
                                w_tick = 1'b1;
                                w_tc   = (r_reload == '0);
                            end else begin
                                w_state = S_DONE;
                            end
                        end else begin
                            w_bcd  = bcd_dec(r_bcd);
                            w_tick = 1'b1;
                            if (r_bcd == W'(1)) begin
                                w_tc = 1'b1;
                                if (!i_auto_reload) w_state = S_DONE;
                            end
                        end
                    end
                end
                S_PAUSED: begin
                    if (i_start && !i_pause) w_state = S_RUN;
                end
                S_DONE: begin
                    if (i_start && !i_pause) begin
                        if (r_reload == '0) begin
                            w_tc = 1'b1;
                        end else begin
                            w_bcd   = r_reload;
                            w_presc = '0;
                            w_state = S_RUN;
                        end
                    end
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_bcd    <= {DIGITS{4'd9}};
            r_reload <= {DIGITS{4'd9}};
            r_presc  <= '0;
            r_tick   <= 1'b0;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_bcd    <= w_bcd;
            r_reload <= w_reload;
            r_presc  <= w_presc;
            r_tick   <= w_tick;
            r_tc     <= w_tc;
        end
    end

    assign o_bcd_out  = r_bcd;
    assign o_running  = (r_state == S_RUN);
    assign o_done     = (r_state == S_DONE);
    assign o_tick     = r_tick;
    assign o_tc_pulse = r_tc;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer (DIGITS=2, TICK_DIV=4): an integer-valued
// reference model queues the expected outputs of every cycle; a monitor compares them.
module tb_bcd_countdown_timer;

    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, ar = 1'b0;
    logic [7:0] lv = 8'h00;
    logic [7:0] o_bcd;
    logic       o_run, o_done, o_tick, o_tc;

    bcd_countdown_timer #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
        .i_clk(clk), .i_reset(reset), .i_load(load), .i_load_val(lv),
        .i_start(start), .i_pause(pause), .i_auto_reload(ar),
        .o_bcd_out(o_bcd), .o_running(o_run), .o_done(o_done),
        .o_tick(o_tick), .o_tc_pulse(o_tc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] bcd;
        logic       run;
        logic       done;
        logic       tick;
        logic       tc;
    } obs_t;

    obs_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: count held as a plain integer, state as a small code.
    int m_val = 99, m_rel = 99, m_pre = 0, m_st = 0; // 0 idle, 1 run, 2 paused, 3 done

    function automatic int bcd_to_int(input logic [7:0] v);
        int t = 0;
        int p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            int d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            t += d * p;
            p *= 10;
        end
        return t;
    endfunction

    function automatic logic [7:0] int_to_bcd(input int n);
        logic [7:0] r = '0;
        int x = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_step(output obs_t e);
        logic tk = 1'b0, tc = 1'b0;
        if (reset) begin
            m_val = 99; m_rel = 99; m_pre = 0; m_st = 0;
        end else if (load) begin
            m_val = bcd_to_int(lv); m_rel = m_val; m_pre = 0; m_st = 0;
        end else begin
            case (m_st)
                0: if (start && !pause) begin
                    if (m_val == 0) begin m_st = 3; tc = 1'b1; end
                    else begin m_st = 1; m_pre = 0; end
                end
                1: if (pause) m_st = 2;
                   else if (m_pre < TICK_DIV - 1) m_pre++;
                   else begin
                       m_pre = 0;
                       if (m_val > 1) begin m_val--; tk = 1'b1; end
                       else if (m_val == 1) begin
                           m_val = 0; tk = 1'b1; tc = 1'b1;
                           if (!ar) m_st = 3;
                       end else if (ar) begin
                           m_val = m_rel; tk = 1'b1; tc = (m_rel == 0);
                       end else m_st = 3;
                   end
                2: if (start && !pause) m_st = 1;
                default: if (start && !pause) begin
                    if (m_rel == 0) tc = 1'b1;
                    else begin m_val = m_rel; m_pre = 0; m_st = 1; end
                end
            endcase
        end
        e.bcd  = int_to_bcd(m_val);
        e.run  = (m_st == 1);
        e.done = (m_st == 3);
        e.tick = tk;
        e.tc   = tc;
    endtask

    task automatic cyc(input logic rs, input logic ld, input logic [7:0] v,
                       input logic st, input logic ps);
        obs_t e;
        @(negedge clk);
        reset = rs; load = ld; lv = v; start = st; pause = ps;
        model_step(e);
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic load_start(input logic [7:0] v);
        cyc(1'b0, 1'b1, v, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    // Monitor: outputs are presented every cycle, checked 1 time unit after the edge.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                a = '{bcd: o_bcd, run: o_run, done: o_done, tick: o_tick, tc: o_tc};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL outputs t=%0t actual bcd=%h run=%b done=%b tick=%b tc=%b expected bcd=%h run=%b done=%b tick=%b tc=%b",
                             $time, a.bcd, a.run, a.done, a.tick, a.tc,
                             e.bcd, e.run, e.done, e.tick, e.tc);
                end
            end
        end
    end

    initial begin
        // Reset held two cycles.
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(3);
        // One-shot countdown from 12 through the 10->09 borrow down to 00 and DONE.
        ar = 1'b0;
        load_start(8'h12);
        idle(60);
        // Auto-reload from 02.
        ar = 1'b1;
        load_start(8'h02);
        idle(30);
        ar = 1'b0;
        // Pause after two prescaler cycles, hold for 10, resume.
        load_start(8'h12);
        idle(2);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(10);
        // Clamped load, load mid-run, start+pause together in RUN.
        load_start(8'hA5);
        idle(6);
        cyc(1'b0, 1'b1, 8'h07, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(2);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        idle(3);
        // DONE restart with reload 03, then zero-value start, then reset on a tick edge.
        load_start(8'h03);
        idle(16);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(3);
        load_start(8'h00);
        idle(3);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle(2);
        load_start(8'h05);
        idle(3);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(2);
        // Randomized traffic, biased towards small load values to exercise zero handling.
        for (int i = 0; i < 3000; i++) begin
            logic       rs, ld, st, ps;
            logic [7:0] v;
            rs = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 59) == 0);
            st = ($urandom_range(0, 7) == 0);
            ps = ($urandom_range(0, 11) == 0);
            v  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            if ($urandom_range(0, 99) == 0) ar = ~ar;
            cyc(rs, ld, v, st, ps);
        end
        idle(2);
        @(posedge clk);
        #2;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain actual %0d pending required 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
